// File: rtl/bpt_pkg.sv
// Shared types for the bad-point table: entry layout, frame state, raster ordering.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: default-geometry entry struct {row,col}, frame FSM state enum, and the
// raster-order compare used to detect an out-of-order table.
package bpt_pkg;

    localparam int BPT_ROW_W   = 10;
    localparam int BPT_COL_W   = 11;
    localparam int BPT_ENTRY_W = BPT_ROW_W + BPT_COL_W;

    // Row in the upper bits, so an unsigned compare of the packed value is raster order.
    typedef struct packed {
        logic [BPT_ROW_W-1:0] row;
        logic [BPT_COL_W-1:0] col;
    } bpt_entry_t;

    typedef enum logic [1:0] {
        BPT_IDLE    = 2'd0,
        BPT_PRELOAD = 2'd1,
        BPT_SCAN    = 2'd2
    } bpt_state_e;

    // True when coordinate a comes strictly after coordinate b in raster order.
    function automatic logic raster_gt(input logic [31:0] a_row, input logic [31:0] a_col,
                                       input logic [31:0] b_row, input logic [31:0] b_col);
        return (a_row > b_row) || ((a_row == b_row) && (a_col > b_col));
    endfunction

endpackage

// File: rtl/bpt_mem.sv
// Coordinate store: DEPTH x DATA_W single-clock RAM, one write port, one read port.
// Latency: read data registered, valid the cycle after raddr_i is presented.
// Backpressure: none; a write and a read may happen every cycle. Contents are not reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i (read address), rdata_o (registered data).
module bpt_mem #(
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128,
    parameter int DATA_W     = 21
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bad_point_table_ctrl.sv
// Manual bad-point table: sorted (row,col) store walked in step with a raster pixel stream.
// Latency: bp_valid/bp_flag/bp_idx registered, exactly 1 cycle after pix_valid.
// Backpressure: none; the pixel stream cannot be stalled, config is refused (cfg_err) outside IDLE.
// Ports: cfg_* write entries and the valid-entry count; pix_* carry the frame stream;
// table_ready is high while scanning; bp_* report the per-pixel lookup result.
// Optional: define BPT_STATS_EN to add stat_hits/stat_miss, latched at every pix_eof.
module bad_point_table_ctrl
    import bpt_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128,
    parameter int ROW_W      = 10,
    parameter int COL_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [ROW_W-1:0]      cfg_row,
    input  logic [COL_W-1:0]      cfg_col,
    input  logic                  cfg_cnt_we,
    input  logic [ADDR_WIDTH:0]   cfg_cnt,
    output logic                  cfg_err,
    input  logic                  pix_sof,
    input  logic                  pix_eof,
    input  logic                  pix_valid,
    input  logic [ROW_W-1:0]      pix_row,
    input  logic [COL_W-1:0]      pix_col,
    output logic                  table_ready,
    output logic                  bp_valid,
    output logic                  bp_flag,
    output logic [ADDR_WIDTH-1:0] bp_idx
`ifdef BPT_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   stat_hits,
    output logic [ADDR_WIDTH:0]   stat_miss
`endif
);

    localparam int ENTRY_W = ROW_W + COL_W;
    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bpt_state_e          state_q, state_d;
    logic                pre_q, pre_d;         // second PRELOAD cycle
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    ptr_q, ptr_d;         // index of head_q
    logic [ENTRY_W-1:0]  head_q, head_d;
    logic [ENTRY_W-1:0]  next_q, next_d;
    logic                fill_q, fill_d;       // rd_data holds entry ptr+1, newer than next_q
    logic                broken_q, broken_d;   // out-of-order entry seen this frame
    logic                cfg_err_q, table_ready_q, bp_valid_q, bp_flag_q;
    logic [ADDR_WIDTH-1:0] bp_idx_q;

    logic                cfg_req, cfg_ok, mem_we, match;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ENTRY_W-1:0]  rd_data, next_eff, pix_coord;

    bpt_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (cfg_addr),
        .wdata_i ({cfg_row, cfg_col}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        cfg_req   = cfg_we | cfg_cnt_we;
        cfg_ok    = cfg_req && (state_q == BPT_IDLE) && !pix_sof;
        mem_we    = cfg_we && cfg_ok;
        pix_coord = {pix_row, pix_col};
        next_eff  = fill_q ? rd_data : next_q;
        // ptr_q < cnt_q also blocks heads fetched past the end of the table.
        match     = (state_q == BPT_SCAN) && !pix_sof && pix_valid && !broken_q &&
                    (ptr_q < cnt_q) && (pix_coord == head_q);

        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        head_d   = head_q;
        next_d   = next_q;
        fill_d   = 1'b0;
        broken_d = broken_q;
        rd_addr  = '0;

        if (cfg_cnt_we && cfg_ok) begin
            cnt_d = (cfg_cnt > DEPTH_C) ? DEPTH_C : cfg_cnt;
        end

        if (pix_sof) begin
            // Restart from any state; address 0 is presented now, head lands next cycle.
            state_d  = BPT_PRELOAD;
            pre_d    = 1'b0;
            ptr_d    = '0;
            broken_d = 1'b0;
            rd_addr  = '0;
        end else begin
            case (state_q)
                BPT_PRELOAD: begin
                    if (!pre_q) begin
                        head_d  = rd_data;
                        rd_addr = ADDR_WIDTH'(1);
                        pre_d   = 1'b1;
                    end else begin
                        next_d  = rd_data;
                        state_d = BPT_SCAN;
                    end
                end
                BPT_SCAN: begin
                    next_d = next_eff;
                    if (match) begin
                        // Fetch ptr+2 now so a match on the very next pixel sees it via rd_data.
                        head_d  = next_eff;
                        ptr_d   = ptr_q + CNT_W'(1);
                        rd_addr = ADDR_WIDTH'(ptr_q + CNT_W'(2));
                        fill_d  = 1'b1;
                        if (!raster_gt(32'(next_eff[ENTRY_W-1:COL_W]), 32'(next_eff[COL_W-1:0]),
                                       32'(head_q[ENTRY_W-1:COL_W]), 32'(head_q[COL_W-1:0]))) begin
                            broken_d = 1'b1;
                        end
                    end
                    if (pix_eof) begin
                        state_d = BPT_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BPT_IDLE;
            pre_q         <= 1'b0;
            cnt_q         <= '0;
            ptr_q         <= '0;
            head_q        <= '0;
            next_q        <= '0;
            fill_q        <= 1'b0;
            broken_q      <= 1'b0;
            cfg_err_q     <= 1'b0;
            table_ready_q <= 1'b0;
            bp_valid_q    <= 1'b0;
            bp_flag_q     <= 1'b0;
            bp_idx_q      <= '0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            head_q        <= head_d;
            next_q        <= next_d;
            fill_q        <= fill_d;
            broken_q      <= broken_d;
            cfg_err_q     <= cfg_req && !cfg_ok;
            table_ready_q <= (state_d == BPT_SCAN);
            bp_valid_q    <= pix_valid;
            bp_flag_q     <= match;
            bp_idx_q      <= match ? ptr_q[ADDR_WIDTH-1:0] : '0;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign table_ready = table_ready_q;
    assign bp_valid    = bp_valid_q;
    assign bp_flag     = bp_flag_q;
    assign bp_idx      = bp_idx_q;

`ifdef BPT_STATS_EN
    logic [CNT_W-1:0] stat_hits_q, stat_miss_q;

    // ptr counts matches since pix_sof, so its next value is the frame's hit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q <= '0;
            stat_miss_q <= '0;
        end else if (pix_eof) begin
            stat_hits_q <= ptr_d;
            stat_miss_q <= cnt_q - ptr_d;
        end
    end

    assign stat_hits = stat_hits_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_bad_point_table_ctrl.sv
// Bench for bad_point_table_ctrl: directed frames against a table-walk reference model.
// Latency: model predicts outputs one cycle after the inputs that cause them.
// Backpressure: none.
module tb_bad_point_table_ctrl;
    import bpt_pkg::*;

    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int ROW_W = 10;
    localparam int COL_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, cfg_we, cfg_cnt_we, pix_sof, pix_eof, pix_valid;
    logic [AW-1:0]    cfg_addr;
    logic [ROW_W-1:0] cfg_row, pix_row;
    logic [COL_W-1:0] cfg_col, pix_col;
    logic [AW:0]      cfg_cnt;
    logic             cfg_err, table_ready, bp_valid, bp_flag;
    logic [AW-1:0]    bp_idx;
`ifdef BPT_STATS_EN
    logic [AW:0]      stat_hits, stat_miss;
`endif

    bad_point_table_ctrl #(
        .ADDR_WIDTH (AW), .DEPTH (DEPTH), .ROW_W (ROW_W), .COL_W (COL_W)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_row (cfg_row), .cfg_col (cfg_col),
        .cfg_cnt_we (cfg_cnt_we), .cfg_cnt (cfg_cnt), .cfg_err (cfg_err),
        .pix_sof (pix_sof), .pix_eof (pix_eof), .pix_valid (pix_valid),
        .pix_row (pix_row), .pix_col (pix_col),
        .table_ready (table_ready), .bp_valid (bp_valid), .bp_flag (bp_flag), .bp_idx (bp_idx)
`ifdef BPT_STATS_EN
        , .stat_hits (stat_hits), .stat_miss (stat_miss)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bpt_entry_t m_tbl [DEPTH];
    int   m_cnt = 0, m_ptr = 0, m_phase = -1, cyc_n = 0;   // phase: -1 idle, 1..2 preload, 3 scan
    logic e_err = 0, e_ready = 0, e_vld = 0, e_flag = 0;
    int   e_idx = 0, s_hits = 0, s_miss = 0;
    int   prev_row = 0, prev_col = 0;

    // Entry p is reachable only if every entry up to it is strictly ascending.
    function automatic bit ordered(input int p);
        return (p == 0) || (m_tbl[p] > m_tbl[p-1]);
    endfunction

    always @(posedge clk) begin
        bit in_idle, in_scan, req;
        int cnt_old;
        cyc_n++;
        prev_row = int'(pix_row);
        prev_col = int'(pix_col);
        if (rst) begin
            m_cnt = 0; m_ptr = 0; m_phase = -1;
            e_err = 0; e_ready = 0; e_vld = 0; e_flag = 0; e_idx = 0;
            s_hits = 0; s_miss = 0;
        end else begin
            in_idle = (m_phase == -1);
            in_scan = (m_phase == 3);
            req     = cfg_we | cfg_cnt_we;
            cnt_old = m_cnt;
            e_err   = req && (!in_idle || pix_sof);
            if (req && in_idle && !pix_sof) begin
                if (cfg_we) m_tbl[cfg_addr] = {cfg_row, cfg_col};
                if (cfg_cnt_we) m_cnt = (int'(cfg_cnt) > DEPTH) ? DEPTH : int'(cfg_cnt);
            end
            e_vld  = pix_valid;
            e_flag = 0;
            e_idx  = 0;
            if (pix_sof) begin
                m_phase = 1;
                m_ptr   = 0;
            end else if (in_scan) begin
                if (pix_valid && m_ptr < m_cnt && ordered(m_ptr) &&
                    {pix_row, pix_col} == m_tbl[m_ptr]) begin
                    e_flag = 1;
                    e_idx  = m_ptr;
                    m_ptr++;
                end
                if (pix_eof) m_phase = -1;
            end else if (m_phase >= 1) begin
                m_phase++;
            end
            if (pix_eof) begin
                s_hits = m_ptr;
                s_miss = cnt_old - m_ptr;
            end
            e_ready = (m_phase == 3);
        end
    end

    // ---------------- per-cycle compare + hit log ----------------
    int log_idx[$], log_row[$], log_col[$], log_cyc[$];
    int err_pulses = 0;

    always @(negedge clk) begin
        chk("cfg_err", cfg_err, e_err);
        chk("table_ready", table_ready, e_ready);
        chk("bp_valid", bp_valid, e_vld);
        chk("bp_flag", bp_flag, e_flag);
        chk("bp_idx", bp_idx, e_idx);
`ifdef BPT_STATS_EN
        chk("stat_hits", stat_hits, s_hits);
        chk("stat_miss", stat_miss, s_miss);
`endif
        if (bp_flag) begin
            log_idx.push_back(int'(bp_idx));
            log_row.push_back(prev_row);
            log_col.push_back(prev_col);
            log_cyc.push_back(cyc_n);
        end
        if (cfg_err) err_pulses++;
    end

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic expect_hit(input string name, input int k, input int idx, input int r, input int c);
        chk({name, "_idx"}, qget(log_idx, k), idx);
        chk({name, "_row"}, qget(log_row, k), r);
        chk({name, "_col"}, qget(log_col, k), c);
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int r, input int c);
        cfg_we = 1; cfg_addr = AW'(a); cfg_row = ROW_W'(r); cfg_col = COL_W'(c);
        cyc();
        cfg_we = 0;
    endtask

    task automatic wr_cnt(input int n);
        cfg_cnt_we = 1; cfg_cnt = (AW+1)'(n);
        cyc();
        cfg_cnt_we = 0;
    endtask

    // 16 columns x 8 rows raster frame with optional fault injections.
    task automatic run_frame(input bit pre_pix, input bit sof_cfg, input int scan_cfg_at, input int rst_at);
        log_idx.delete(); log_row.delete(); log_col.delete(); log_cyc.delete();
        err_pulses = 0;
        pix_sof = 1;
        if (sof_cfg) begin cfg_cnt_we = 1; cfg_cnt = '0; end
        cyc();
        pix_sof = 0; cfg_cnt_we = 0;
        if (pre_pix) begin pix_valid = 1; pix_row = 2; pix_col = 5; end
        cyc();
        pix_valid = 0;
        if (pre_pix) begin
            chk("preload_vld", bp_valid, 1);
            chk("preload_flag", bp_flag, 0);
            chk("preload_ready", table_ready, 0);
        end
        cyc();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                int n;
                n = r * 16 + c;
                pix_valid = 1; pix_row = ROW_W'(r); pix_col = COL_W'(c);
                if (n == scan_cfg_at) begin cfg_we = 1; cfg_addr = '0; cfg_row = '0; cfg_col = '0; end
                if (n == rst_at) begin
                    rst = 1;
                    cyc();
                    rst = 0; pix_valid = 0;
                    chk("midrst_ready", table_ready, 0);
                    chk("midrst_flag", bp_flag, 0);
                    chk("midrst_vld", bp_valid, 0);
                    return;
                end
                cyc();
                cfg_we = 0;
            end
        end
        pix_valid = 0; pix_eof = 1;
        cyc();
        pix_eof = 0;
        cyc(); cyc();
    endtask

    task automatic check_base_frame(input string tag);
        chk({tag, "_nhits"}, log_idx.size(), 3);
        expect_hit({tag, "_h0"}, 0, 0, 2, 5);
        expect_hit({tag, "_h1"}, 1, 1, 2, 6);
        expect_hit({tag, "_h2"}, 2, 2, 7, 0);
        chk({tag, "_b2b"}, qget(log_cyc, 1) - qget(log_cyc, 0), 1);
    endtask

    initial begin
        rst = 1; cfg_we = 1; cfg_cnt_we = 0; pix_sof = 0; pix_eof = 0; pix_valid = 1;
        cfg_addr = '0; cfg_row = '0; cfg_col = '0; cfg_cnt = '0; pix_row = '0; pix_col = '0;
        cyc(); cyc(); cyc();
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_ready", table_ready, 0);
        chk("rst_vld", bp_valid, 0);
        chk("rst_flag", bp_flag, 0);
        chk("rst_idx", bp_idx, 0);
        rst = 0; cfg_we = 0; pix_valid = 0;
        cyc();

        // Base table; entry 2 and the count written in the same cycle.
        wr(0, 2, 5);
        wr(1, 2, 6);
        cfg_we = 1; cfg_addr = 2; cfg_row = 7; cfg_col = 0;
        cfg_cnt_we = 1; cfg_cnt = 3;
        cyc();
        cfg_we = 0; cfg_cnt_we = 0;
        run_frame(1, 0, -1, -1);
        check_base_frame("f1");
`ifdef BPT_STATS_EN
        chk("f1_stat_hits", stat_hits, 3);
        chk("f1_stat_miss", stat_miss, 0);
`endif

        // Config write during SCAN is refused.
        run_frame(0, 0, 0, -1);
        chk("scan_cfg_err_pulses", err_pulses, 1);
        check_base_frame("f2");
        // Count write coinciding with pix_sof is refused; table intact.
        run_frame(0, 1, -1, -1);
        chk("sof_cfg_err_pulses", err_pulses, 1);
        check_base_frame("f3");

        // Empty table.
        wr_cnt(0);
        run_frame(0, 0, -1, -1);
        chk("cnt0_nhits", log_idx.size(), 0);

        // Every pixel listed; count 200 clamps to 128.
        for (int i = 0; i < DEPTH; i++) wr(i, i / 16, i % 16);
        wr_cnt(200);
        run_frame(0, 0, -1, -1);
        chk("full_nhits", log_idx.size(), 128);
        expect_hit("full_first", 0, 0, 0, 0);
        expect_hit("full_last", 127, 127, 7, 15);
`ifdef BPT_STATS_EN
        chk("full_stat_hits", stat_hits, 128);
        chk("full_stat_miss", stat_miss, 0);
`endif

        // Out-of-order table: only the first entry is reachable.
        wr(0, 3, 3); wr(1, 1, 1); wr(2, 4, 4);
        wr_cnt(3);
        run_frame(0, 0, -1, -1);
        chk("unsorted_nhits", log_idx.size(), 1);
        expect_hit("unsorted_h0", 0, 0, 3, 3);
`ifdef BPT_STATS_EN
        chk("unsorted_stat_hits", stat_hits, 1);
        chk("unsorted_stat_miss", stat_miss, 2);
`endif

        // Reset mid-SCAN at (2,5); memory survives, count is reloaded.
        wr(0, 2, 5); wr(1, 2, 6); wr(2, 7, 0);
        wr_cnt(3);
        run_frame(0, 0, -1, 37);
        chk("midrst_nhits", log_idx.size(), 0);
        cyc();
        wr_cnt(3);
        run_frame(0, 0, -1, -1);
        check_base_frame("f_after_rst");

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bad_point_table_ctrl.md
Name: bad_point_table_ctrl

Overview:
- Next-generation manual bad-point table: parametrised coordinate store plus raster-scan lookup engine.
- Config side writes sorted (row,col) entries and an entry count.
- Pixel side walks the table in step with the pixel stream and emits a per-pixel bad flag, ahead of the DPC correction stage.
- Single clock domain; one sequential read pointer replaces random-address queries.

Parameters:
- ADDR_WIDTH, 7, table address width.
- DEPTH, 128, entry count; must equal 2**ADDR_WIDTH.
- ROW_W, 10, row coordinate width.
- COL_W, 11, column coordinate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  write entry at cfg_addr.
- cfg_addr  in  ADDR_WIDTH  entry address.
- cfg_row  in  ROW_W  entry row.
- cfg_col  in  COL_W  entry column.
- cfg_cnt_we  in  1  load valid-entry count.
- cfg_cnt  in  ADDR_WIDTH+1  number of valid entries.
- cfg_err  out  1  one-cycle pulse: config write rejected.
- pix_sof  in  1  start of frame, one cycle.
- pix_eof  in  1  end of frame, one cycle.
- pix_valid  in  1  pixel coordinate valid.
- pix_row  in  ROW_W  current pixel row.
- pix_col  in  COL_W  current pixel column.
- table_ready  out  1  prefetch complete; lookups valid.
- bp_valid  out  1  pix_valid delayed 1 cycle.
- bp_flag  out  1  current pixel is a listed bad point.
- bp_idx  out  ADDR_WIDTH  matched entry index; 0 when bp_flag=0.

Behaviour:
- Entry stored as {row,col}, ROW_W+COL_W bits. Memory read is registered, 1-cycle latency.
- Reset: cnt=0, ptr=0, frame inactive. All outputs 0: cfg_err, table_ready, bp_valid, bp_flag, bp_idx. Memory contents are not cleared.
- Frame state machine: IDLE -> (pix_sof) PRELOAD -> 2 cycles -> SCAN -> (pix_eof) IDLE.
  - pix_sof in any state restarts PRELOAD with ptr=0.
- PRELOAD loads head=entry[0] and next=entry[1]. table_ready=1 only in SCAN.
- SCAN: for each pix_valid, compare {pix_row,pix_col} with head.
  - Match only if ptr<cnt.
  - On match, one cycle later: bp_flag=1, bp_idx=ptr. Then head<=next, ptr+1, fetch ptr+2 into next.
  - Sustains matches on consecutive pix_valid cycles (adjacent bad pixels).
- Latency: bp_valid/bp_flag/bp_idx are registered, exactly 1 cycle after pix_valid, in every state.
- Outside SCAN (IDLE, PRELOAD, after reset mid-frame until next pix_sof): bp_flag=0, but bp_valid still follows pix_valid.
- Table must be strictly ascending in raster order (row major, then col). After an out-of-order entry, no further entries match until the next pix_sof. Pointer never skips.
- ptr saturates at cnt; prefetch beyond DEPTH-1 yields no-match.
- cnt=0: no pixel ever flagged.
- Config accepted only in IDLE.
  - cfg_we or cfg_cnt_we outside IDLE: ignored, cfg_err=1 next cycle.
  - Config write in the same cycle as pix_sof: rejected.
- cfg_cnt > DEPTH is clamped to DEPTH.
- Simultaneous cfg_we and cfg_cnt_we in IDLE: both take effect.

Optional Feature:
- Macro BPT_STATS_EN.
- Defined: adds outputs stat_hits (ADDR_WIDTH+1) and stat_miss (ADDR_WIDTH+1).
  - Both update on pix_eof: hits = matches in the frame, miss = cnt - hits.
  - Both hold until the next pix_eof. Reset value 0.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bpt_pkg holds:
  - the coordinate entry struct/width constant (ROW_W+COL_W);
  - the frame state enum (IDLE, PRELOAD, SCAN);
  - a raster-compare function.
- One sub-module, bpt_mem: simple single-clock RAM with one write port and one registered read port, DEPTH x (ROW_W+COL_W).

Test Plan:
- Load cnt=3 with entries (2,5),(2,6),(7,0); stream a 16x8 frame -> bp_flag high exactly at those coords, 1 cycle late, with bp_idx 0,1,2 (back-to-back at (2,5)/(2,6)).
- cfg_we during SCAN -> cfg_err pulses once; memory unchanged; next frame flags as before.
- cnt=0 and cfg_cnt=200 -> first flags nothing; second clamps to 128, all 128 entries matchable.
- Unsorted table (3,3),(1,1),(4,4) -> only (3,3) flagged. With BPT_STATS_EN: stat_hits=1, stat_miss=2 after pix_eof.
- rst asserted mid-SCAN -> next cycle table_ready=0, bp_flag=0. After the next pix_sof, entries match again from index 0.
- pix_valid during PRELOAD (within 2 cycles of pix_sof) at a listed coordinate -> bp_valid=1, bp_flag=0, table_ready=0.
